// File: rtl/rangefinder_driver.sv
// rangefinder_driver: buffers up to DEPTH host samples and replays them to a
// rangefinder over the go/finish streaming protocol, then captures the
// returned range/error flag and reports them with a one-cycle done pulse.
module rangefinder_driver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     result_err,
  output logic                     rf_go,
  output logic                     rf_finish,
  output logic [WIDTH-1:0]         rf_data,
  input  logic [WIDTH-1:0]         rf_range,
  input  logic                     rf_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, FIN, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    idx_nxt;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] buf_d [DEPTH];
  logic             full_q, full_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_err_q, result_err_d;
  logic             rf_go_q, rf_go_d;
  logic             rf_finish_q, rf_finish_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;

  // Next-state and registered-output computation. state_q names the cycle the
  // outputs currently show; count_q stays frozen during a replay and is the N.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    result_d     = result_q;
    result_err_d = result_err_q;
    rf_go_d      = 1'b0;
    rf_finish_d  = 1'b0;
    rf_data_d    = '0;
    idx_nxt      = idx_q + AW'(1);

    case (state_q)
      IDLE: begin
        if (start && (count_q != '0)) begin
          state_d   = SEND;
          idx_d     = '0;
          busy_d    = 1'b1;
          rf_go_d   = 1'b1;
          rf_data_d = buf_q[0];
        end else if (!start && wr_en && (count_q != DEPTH_C)) begin
          buf_d[count_q[AW-1:0]] = wr_data;
          count_d                = count_q + CW'(1);
        end
      end
      SEND: begin
        busy_d = 1'b1;
        if ({1'b0, idx_q} == (count_q - CW'(1))) begin
          state_d     = FIN;
          rf_finish_d = 1'b1;
          rf_data_d   = rf_data_q;
        end else begin
          idx_d     = idx_nxt;
          rf_data_d = buf_q[idx_nxt];
        end
      end
      FIN: begin
        busy_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        state_d      = IDLE;
        done_d       = 1'b1;
        result_d     = rf_range;
        result_err_d = rf_error;
        count_d      = '0;
      end
      default: state_d = IDLE;
    endcase

    full_d = (count_d == DEPTH_C);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      result_err_q <= 1'b0;
      rf_go_q      <= 1'b0;
      rf_finish_q  <= 1'b0;
      rf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      full_q       <= full_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      result_err_q <= result_err_d;
      rf_go_q      <= rf_go_d;
      rf_finish_q  <= rf_finish_d;
      rf_data_q    <= rf_data_d;
    end
  end

  // Sample buffer storage; contents survive reset and completion.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign count      = count_q;
  assign full       = full_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign result_err = result_err_q;
  assign rf_go      = rf_go_q;
  assign rf_finish  = rf_finish_q;
  assign rf_data    = rf_data_q;

endmodule

// File: tb/tb_rangefinder_driver.sv
// Directed, table-driven bench for rangefinder_driver (WIDTH=16, DEPTH=8).
module tb_rangefinder_driver;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        start;
  logic [3:0]  count;
  logic        full;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        result_err;
  logic        rf_go;
  logic        rf_finish;
  logic [15:0] rf_data;
  logic [15:0] rf_range;
  logic        rf_error;

  int n_chk;
  int n_pass;

  rangefinder_driver #(.WIDTH(16), .DEPTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .result_err (result_err),
    .rf_go      (rf_go),
    .rf_finish  (rf_finish),
    .rf_data    (rf_data),
    .rf_range   (rf_range),
    .rf_error   (rf_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned rst, we, wd, st, rng, err;
    int unsigned e_count, e_full, e_busy, e_done, e_res, e_rerr, e_go, e_fin, e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Advance one edge and sample 1 time unit later; go/finish must never overlap.
  task automatic step();
    @(posedge clock);
    #1;
    check("go_finish_exclusive", 32'(rf_go & rf_finish), 0);
  endtask

  task automatic add(input int unsigned rst, we, wd, st, rng, err,
                     input int unsigned ec, ef, eb, ed, er, ee, eg, efn, edt);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.st = st; v.rng = rng; v.err = err;
    v.e_count = ec; v.e_full = ef; v.e_busy = eb; v.e_done = ed; v.e_res = er;
    v.e_rerr = ee; v.e_go = eg; v.e_fin = efn; v.e_data = edt;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
  endtask

  task automatic write(input int unsigned d);
    wr_en = 1'b1; wr_data = 16'(d); start = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int cyc;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    rf_range = 16'h1111; rf_error = 1'b0;
    step();

    //   rst we wd  st rng     err | cnt full busy done res    rerr go fin data
    add(1, 0, 0,  0, 16'h1111, 0,   0, 0, 0, 0, 0,       0, 0, 0, 0);   // reset state
    add(0, 1, 3,  0, 16'h1111, 0,   1, 0, 0, 0, 0,       0, 0, 0, 0);
    add(0, 1, 9,  0, 16'h1111, 0,   2, 0, 0, 0, 0,       0, 0, 0, 0);
    add(0, 1, 5,  0, 16'h1111, 0,   3, 0, 0, 0, 0,       0, 0, 0, 0);
    add(0, 0, 0,  1, 16'h1111, 0,   3, 0, 1, 0, 0,       0, 1, 0, 3);   // SEND k=0
    add(0, 0, 0,  0, 16'h1111, 0,   3, 0, 1, 0, 0,       0, 0, 0, 9);
    add(0, 0, 0,  0, 16'h1111, 0,   3, 0, 1, 0, 0,       0, 0, 0, 5);
    add(0, 0, 0,  0, 16'h1111, 0,   3, 0, 1, 0, 0,       0, 0, 1, 5);   // FIN
    add(0, 0, 0,  0, 16'h1111, 0,   3, 0, 1, 0, 0,       0, 0, 0, 0);   // WAIT
    add(0, 0, 0,  0, 6,        0,   0, 0, 0, 1, 6,       0, 0, 0, 0);   // done, start+6
    add(0, 0, 0,  0, 16'h1111, 0,   0, 0, 0, 0, 6,       0, 0, 0, 0);
    add(0, 0, 0,  1, 16'h1111, 0,   0, 0, 0, 0, 6,       0, 0, 0, 0);   // start, empty
    add(0, 1, 42, 0, 16'h1111, 0,   1, 0, 0, 0, 6,       0, 0, 0, 0);
    add(0, 1, 77, 1, 16'h1111, 0,   1, 0, 1, 0, 6,       0, 1, 0, 42);  // start beats write
    add(0, 1, 77, 1, 16'h1111, 0,   1, 0, 1, 0, 6,       0, 0, 1, 42);  // N=1 FIN
    add(0, 1, 77, 0, 16'h1111, 0,   1, 0, 1, 0, 6,       0, 0, 0, 0);   // WAIT
    add(0, 1, 77, 1, 16'hBEEF, 1,   0, 0, 0, 1, 16'hBEEF, 1, 0, 0, 0);  // done, start+4
    add(0, 0, 0,  0, 16'h1111, 0,   0, 0, 0, 0, 16'hBEEF, 1, 0, 0, 0);  // result held
    add(0, 0, 0,  0, 16'h2222, 0,   0, 0, 0, 0, 16'hBEEF, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset    = 1'(vecs[i].rst);
      wr_en    = 1'(vecs[i].we);
      wr_data  = 16'(vecs[i].wd);
      start    = 1'(vecs[i].st);
      rf_range = 16'(vecs[i].rng);
      rf_error = 1'(vecs[i].err);
      step();
      check($sformatf("v%0d_count", i), 32'(count), vecs[i].e_count);
      check($sformatf("v%0d_full", i), 32'(full), vecs[i].e_full);
      check($sformatf("v%0d_busy", i), 32'(busy), vecs[i].e_busy);
      check($sformatf("v%0d_done", i), 32'(done), vecs[i].e_done);
      check($sformatf("v%0d_result", i), 32'(result), vecs[i].e_res);
      check($sformatf("v%0d_result_err", i), 32'(result_err), vecs[i].e_rerr);
      check($sformatf("v%0d_rf_go", i), 32'(rf_go), vecs[i].e_go);
      check($sformatf("v%0d_rf_finish", i), 32'(rf_finish), vecs[i].e_fin);
      check($sformatf("v%0d_rf_data", i), 32'(rf_data), vecs[i].e_data);
    end
    idle_inputs();
    rf_range = 16'h0055; rf_error = 1'b0;

    // Overfill: 9 writes into DEPTH=8, then replay 1..8.
    for (int k = 1; k <= 9; k++) begin
      write(k);
      check($sformatf("fill%0d_count", k), 32'(count), (k > 8) ? 8 : k);
      check($sformatf("fill%0d_full", k), 32'(full), (k >= 8) ? 1 : 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("ovf_go0", 32'(rf_go), 1);
    check("ovf_data0", 32'(rf_data), 1);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("ovf_go%0d", k), 32'(rf_go), 0);
      check($sformatf("ovf_fin%0d", k), 32'(rf_finish), 0);
      check($sformatf("ovf_data%0d", k), 32'(rf_data), k + 1);
    end
    step();
    check("ovf_fin", 32'(rf_finish), 1);
    check("ovf_fin_data", 32'(rf_data), 8);
    step();
    check("ovf_wait_done", 32'(done), 0);
    check("ovf_wait_busy", 32'(busy), 1);
    step();
    check("ovf_done_at_11", 32'(done), 1);
    check("ovf_result", 32'(result), 16'h0055);
    check("ovf_count", 32'(count), 0);
    check("ovf_full", 32'(full), 0);

    // Reset during SEND after 2 of 4 samples.
    step();
    for (int k = 1; k <= 4; k++) write(10 * k);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst_seq_data0", 32'(rf_data), 10);
    step();
    check("rst_seq_data1", 32'(rf_data), 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_outputs",
          32'({count, full, busy, done, result, result_err, rf_go, rf_finish, rf_data}), 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rst_no_done%0d", k), 32'({done, busy, rf_go, rf_finish}), 0);
    end

    // Recovery after reset: single sample, bounded wait for done.
    rf_range = 16'h0123;
    write(7);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rec_go", 32'(rf_go), 1);
    check("rec_data", 32'(rf_data), 7);
    cyc = 1;
    while (!done && cyc < 12) begin
      step();
      cyc++;
    end
    check("rec_latency", 32'(cyc), 4);
    check("rec_result", 32'(result), 16'h0123);
    check("rec_result_err", 32'(result_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
